// File: rtl/traffic_cmd_sequencer.sv
// Turns host mode requests (OFF / NORMAL / BLINK) into ordered, gap-spaced command packets for traffic_lights.
// Optional build macro TLS_AUTO_START_EN: run a default NORMAL sequence right after reset release.
module traffic_cmd_sequencer #(
    parameter int unsigned CMD_GAP       = 2,
    parameter logic [15:0] DEF_RED_MS    = 16'd10,
    parameter logic [15:0] DEF_YELLOW_MS = 16'd3,
    parameter logic [15:0] DEF_GREEN_MS  = 16'd8
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic [1:0]  mode_i,
    input  logic        mode_valid_i,
    output logic        mode_ready_o,
    input  logic [15:0] red_ms_i,
    input  logic [15:0] yellow_ms_i,
    input  logic [15:0] green_ms_i,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic [1:0]  cur_mode_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_e;

    typedef enum logic [2:0] {
        CMD_ON         = 3'd0,
        CMD_OFF        = 3'd1,
        CMD_BLINK      = 3'd2,
        CMD_SET_GREEN  = 3'd3,
        CMD_SET_RED    = 3'd4,
        CMD_SET_YELLOW = 3'd5
    } cmd_e;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_NORMAL  = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam int unsigned GAP_W = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (CMD_GAP > 0) ? GAP_W'(CMD_GAP - 1) : '0;

`ifdef TLS_AUTO_START_EN
    localparam bit AUTO_START = 1'b1;
`else
    localparam bit AUTO_START = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         tgt_q, tgt_d;
    logic [15:0]        red_q, red_d;
    logic [15:0]        yel_q, yel_d;
    logic [15:0]        grn_q, grn_d;
    logic [1:0]         cur_q, cur_d;
    logic               err_q, err_d;
    logic               init_q, init_d;
    logic [2:0]         hold_type_q, hold_type_d;
    logic [15:0]        hold_data_q, hold_data_d;

    logic [2:0]         issue_type;
    logic [15:0]        issue_data;
    logic               accept;
    logic               req_illegal;
    logic               req_noop;

    // init_q keeps the host port closed during the first cycle after reset release.
    assign mode_ready_o = (state_q == ST_IDLE) && init_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign cmd_valid_o  = (state_q == ST_ISSUE);
    assign cmd_type_o   = cmd_valid_o ? issue_type : hold_type_q;
    assign cmd_data_o   = cmd_valid_o ? issue_data : hold_data_q;
    assign cur_mode_o   = cur_q;
    assign err_o        = err_q;

    assign accept      = mode_valid_i && mode_ready_o;
    assign req_illegal = (mode_i == MODE_ILLEGAL) ||
                         ((mode_i == MODE_NORMAL) &&
                          ((red_ms_i == '0) || (yellow_ms_i == '0) || (green_ms_i == '0)));
    assign req_noop    = (mode_i != MODE_NORMAL) && (mode_i == cur_q);

    // Command for the current sequence step; NORMAL walks red, yellow, green, then ON.
    always_comb begin
        issue_type = CMD_OFF;
        issue_data = '0;
        case (tgt_q)
            MODE_NORMAL: begin
                case (idx_q)
                    2'd0:    begin issue_type = CMD_SET_RED;    issue_data = red_q; end
                    2'd1:    begin issue_type = CMD_SET_YELLOW; issue_data = yel_q; end
                    2'd2:    begin issue_type = CMD_SET_GREEN;  issue_data = grn_q; end
                    default: begin issue_type = CMD_ON;         issue_data = '0;    end
                endcase
            end
            MODE_BLINK: issue_type = CMD_BLINK;
            default:    issue_type = CMD_OFF;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        last_d      = last_q;
        tgt_d       = tgt_q;
        red_d       = red_q;
        yel_d       = yel_q;
        grn_d       = grn_q;
        cur_d       = cur_q;
        err_d       = 1'b0;
        init_d      = 1'b1;
        hold_type_d = hold_type_q;
        hold_data_d = hold_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!init_q) begin
                    if (AUTO_START) begin
                        tgt_d   = MODE_NORMAL;
                        red_d   = DEF_RED_MS;
                        yel_d   = DEF_YELLOW_MS;
                        grn_d   = DEF_GREEN_MS;
                        idx_d   = 2'd0;
                        last_d  = 2'd3;
                        state_d = ST_ISSUE;
                    end
                end else if (accept) begin
                    if (req_illegal) begin
                        err_d = 1'b1;
                    end else if (!req_noop) begin
                        tgt_d   = mode_i;
                        red_d   = red_ms_i;
                        yel_d   = yellow_ms_i;
                        grn_d   = green_ms_i;
                        idx_d   = 2'd0;
                        // Re-timing an already running NORMAL skips the trailing ON.
                        if (mode_i == MODE_NORMAL) begin
                            last_d = (cur_q == MODE_NORMAL) ? 2'd2 : 2'd3;
                        end else begin
                            last_d = 2'd0;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                hold_type_d = issue_type;
                hold_data_d = issue_data;
                if (idx_q == last_q) begin
                    cur_d   = tgt_q;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    gap_d   = '0;
                    state_d = (CMD_GAP > 0) ? ST_GAP : ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (!arst_ni) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            tgt_q       <= MODE_OFF;
            red_q       <= '0;
            yel_q       <= '0;
            grn_q       <= '0;
            cur_q       <= MODE_OFF;
            err_q       <= 1'b0;
            init_q      <= 1'b0;
            hold_type_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            tgt_q       <= tgt_d;
            red_q       <= red_d;
            yel_q       <= yel_d;
            grn_q       <= grn_d;
            cur_q       <= cur_d;
            err_q       <= err_d;
            init_q      <= init_d;
            hold_type_q <= hold_type_d;
            hold_data_q <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_traffic_cmd_sequencer.sv
// Directed bench for traffic_cmd_sequencer: two instances (CMD_GAP=2 and CMD_GAP=0) checked against a strobe scoreboard.
`timescale 1ns/1ps
module tb_traffic_cmd_sequencer;

    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
    localparam logic [15:0] DEF_R = 16'd10;
    localparam logic [15:0] DEF_Y = 16'd3;
    localparam logic [15:0] DEF_G = 16'd8;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic [1:0]  mode;
    logic [15:0] red, yel, grn;
    logic [1:0]  valid_w;
    logic [1:0]  rdy_w, cvld_w, busy_w, err_w;
    logic [2:0]  type_a, type_b;
    logic [15:0] data_a, data_b;
    logic [1:0]  cur_a, cur_b;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [1:0] m_cur [2];
    int   exp_n [2];
    bit   exp_err [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    traffic_cmd_sequencer #(.CMD_GAP(GAP_A)) u_dut_a (
        .clk_i(clk), .arst_ni(arst_ni),
        .mode_i(mode), .mode_valid_i(valid_w[0]), .mode_ready_o(rdy_w[0]),
        .red_ms_i(red), .yellow_ms_i(yel), .green_ms_i(grn),
        .cmd_type_o(type_a), .cmd_valid_o(cvld_w[0]), .cmd_data_o(data_a),
        .cur_mode_o(cur_a), .busy_o(busy_w[0]), .err_o(err_w[0])
    );

    traffic_cmd_sequencer #(.CMD_GAP(GAP_B)) u_dut_b (
        .clk_i(clk), .arst_ni(arst_ni),
        .mode_i(mode), .mode_valid_i(valid_w[1]), .mode_ready_o(rdy_w[1]),
        .red_ms_i(red), .yellow_ms_i(yel), .green_ms_i(grn),
        .cmd_type_o(type_b), .cmd_valid_o(cvld_w[1]), .cmd_data_o(data_b),
        .cur_mode_o(cur_b), .busy_o(busy_w[1]), .err_o(err_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int sel, input logic [2:0] t, input logic [15:0] d, input int acc);
        exp_t e;
        int gap = (sel == 0) ? GAP_A : GAP_B;
        e.t = t;
        e.d = d;
        e.c = acc + exp_n[sel] * (gap + 1);
        exp_n[sel]++;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Expected command stream for one accepted request, from the behaviour description.
    task automatic model(input int sel, input logic [1:0] m, input logic [15:0] r, y, g, input int acc);
        exp_err[sel] = 1'b0;
        exp_n[sel]   = 0;
        if (m == 2'b11 || (m == 2'b01 && (r == 0 || y == 0 || g == 0))) begin
            exp_err[sel] = 1'b1;
        end else if (m == 2'b01) begin
            push(sel, 3'd4, r, acc);
            push(sel, 3'd5, y, acc);
            push(sel, 3'd3, g, acc);
            if (m_cur[sel] != 2'b01) push(sel, 3'd0, 16'd0, acc);
            m_cur[sel] = 2'b01;
        end else if (m != m_cur[sel]) begin
            push(sel, (m == 2'b00) ? 3'd1 : 3'd2, 16'd0, acc);
            m_cur[sel] = m;
        end
    endtask

    task automatic mon(input int sel, input logic [2:0] t, input logic [15:0] d);
        exp_t e;
        n_assert++;
        assert (qsize(sel) > 0) else begin
            n_fail++;
            $error("FAIL strobe_unexpected[%0d]: observed type %0d data %0d at cycle %0d, expected none", sel, t, d, cyc);
        end
        if (qsize(sel) > 0) begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("strobe_type[%0d]", sel), t, e.t);
            chk($sformatf("strobe_data[%0d]", sel), d, e.d);
            chk($sformatf("strobe_cycle[%0d]", sel), cyc, e.c);
        end
    endtask

    always @(negedge clk) if (arst_ni === 1'b1 && cvld_w[0]) mon(0, type_a, data_a);
    always @(negedge clk) if (arst_ni === 1'b1 && cvld_w[1]) mon(1, type_b, data_b);

    task automatic send(input int sel, input logic [1:0] m, input logic [15:0] r, y, g, output int acc);
        int n = 0;
        mode = m; red = r; yel = y; grn = g;
        valid_w[sel] = 1'b1;
        @(negedge clk);
        while (!rdy_w[sel] && n < 200) begin @(negedge clk); n++; end
        n_assert++;
        assert (n < 200) else begin n_fail++; $error("FAIL ready_timeout[%0d]: observed %0d cycles expected < 200", sel, n); end
        @(posedge clk); #1;
        acc = cyc;
        valid_w[sel] = 1'b0;
        model(sel, m, r, y, g, acc);
        chk($sformatf("err_pulse[%0d]", sel), err_w[sel], exp_err[sel]);
        chk($sformatf("busy_accept[%0d]", sel), busy_w[sel], exp_n[sel] > 0);
    endtask

    task automatic wait_done(input int sel);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (qsize(sel) != 0 && n < 200);
        chk($sformatf("done_queue[%0d]", sel), qsize(sel), 0);
        chk($sformatf("cur_mode[%0d]", sel), (sel == 0) ? cur_a : cur_b, m_cur[sel]);
        chk($sformatf("ready_after[%0d]", sel), rdy_w[sel], 1'b1);
        chk($sformatf("busy_after[%0d]", sel), busy_w[sel], 1'b0);
        chk($sformatf("err_low[%0d]", sel), err_w[sel], 1'b0);
    endtask

    task automatic do_reset();
        int acc;
        arst_ni = 1'b0;
        valid_w = '0;
        q0.delete();
        q1.delete();
        m_cur[0] = 2'b00;
        m_cur[1] = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy_w, 2'b00);
        chk("rst_valid", cvld_w, 2'b00);
        chk("rst_busy", busy_w, 2'b00);
        chk("rst_err", err_w, 2'b00);
        chk("rst_type_a", type_a, 3'd0);
        chk("rst_data_a", data_a, 16'd0);
        chk("rst_cur_b", cur_b, 2'b00);
        arst_ni = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
`ifdef TLS_AUTO_START_EN
        model(0, 2'b01, DEF_R, DEF_Y, DEF_G, acc);
        model(1, 2'b01, DEF_R, DEF_Y, DEF_G, acc);
        chk("auto_ready", rdy_w, 2'b00);
        wait_done(0);
        wait_done(1);
`else
        chk("release_ready", rdy_w, 2'b11);
        chk("release_cur_a", cur_a, 2'b00);
`endif
    endtask

    initial begin
        int acc1, acc2, n1, k;
        mode = '0; red = '0; yel = '0; grn = '0; valid_w = '0;
        arst_ni = 1'b0;
        do_reset();

        // NORMAL from OFF with spaced commands, then BLINK / OFF back-to-back on the zero-gap instance
        send(0, 2'b01, 16'd10, 16'd3, 16'd8, acc1); wait_done(0);
        send(1, 2'b10, 16'd0, 16'd0, 16'd0, acc1); wait_done(1);
        send(1, 2'b00, 16'd0, 16'd0, 16'd0, acc1); wait_done(1);
        send(1, 2'b01, 16'd100, 16'd1, 16'd65535, acc1); wait_done(1);

        // Re-timing while NORMAL, illegal requests, same-mode requests
        send(0, 2'b01, 16'd5, 16'd2, 16'd6, acc1); wait_done(0);
        send(0, 2'b11, 16'd5, 16'd2, 16'd6, acc1); wait_done(0);
        send(0, 2'b01, 16'd5, 16'd2, 16'd0, acc1); wait_done(0);
        send(1, 2'b00, 16'd0, 16'd0, 16'd0, acc1); wait_done(1);
        send(1, 2'b00, 16'd0, 16'd0, 16'd0, acc1); wait_done(1);
        send(0, 2'b10, 16'd0, 16'd0, 16'd0, acc1); wait_done(0);
        send(0, 2'b10, 16'd0, 16'd0, 16'd0, acc1); wait_done(0);

        // Request held during a busy sequence is taken one cycle after the last strobe
        send(0, 2'b01, 16'd7, 16'd4, 16'd9, acc1);
        n1 = exp_n[0];
        send(0, 2'b00, 16'd0, 16'd0, 16'd0, acc2);
        chk("stall_accept_cycle", acc2 - acc1, (n1 > 0) ? (n1 - 1) * (GAP_A + 1) + 2 : 1);
        wait_done(0);

        // Reset between the 2nd and 3rd strobe of a NORMAL sequence
        send(0, 2'b01, 16'd10, 16'd3, 16'd8, acc1);
        n1 = exp_n[0];
        k = 0;
        while (qsize(0) > n1 - 2 && k < 100) begin @(posedge clk); #1; k++; end
        chk("midseq_progress", qsize(0), n1 - 2);
        arst_ni = 1'b0;
        #1;
        chk("midrst_valid", cvld_w[0], 1'b0);
        chk("midrst_cur", cur_a, 2'b00);
        chk("midrst_busy", busy_w[0], 1'b0);
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_queue_a", qsize(0), 0);
        chk("post_reset_cur_a", cur_a, m_cur[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_cmd_sequencer.md
Name: traffic_cmd_sequencer

Overview:
Controller that sits in front of the traffic_lights block and drives its command port (cmd_type/cmd_valid/cmd_data).
A host issues high-level mode requests (OFF, NORMAL with durations, BLINK) over a valid/ready handshake.
The sequencer expands each request into the ordered, spaced command packets the light controller expects.
It tracks the currently applied mode and flags illegal requests.

Parameters:
CMD_GAP, 2, idle cycles with cmd_valid_o low inserted after every issued command (0 = back-to-back)
DEF_RED_MS, 10, red duration used by the auto-start sequence (see Optional Feature)
DEF_YELLOW_MS, 3, yellow duration used by auto-start
DEF_GREEN_MS, 8, green duration used by auto-start

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous reset, active low
mode_i  in  2  requested mode: 00 OFF, 01 NORMAL, 10 BLINK, 11 illegal
mode_valid_i  in  1  request valid
mode_ready_o  out  1  request accepted on mode_valid_i && mode_ready_o
red_ms_i  in  16  red duration, sampled at accept (NORMAL only)
yellow_ms_i  in  16  yellow duration, sampled at accept
green_ms_i  in  16  green duration, sampled at accept
cmd_type_o  out  3  command code: 0 ON, 1 OFF, 2 BLINK, 3 SET_GREEN, 4 SET_RED, 5 SET_YELLOW
cmd_valid_o  out  1  single-cycle command strobe
cmd_data_o  out  16  command payload; 0 for ON/OFF/BLINK
cur_mode_o  out  2  last fully applied mode
busy_o  out  1  sequence in progress (inverse of mode_ready_o outside reset)
err_o  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset values (arst_ni low, applied asynchronously):
  - mode_ready_o=0, cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, cur_mode_o=00, busy_o=0, err_o=0.
  - State=IDLE; gap counter=0.
  - First edge after release: mode_ready_o=1.
- FSM states: IDLE, ISSUE, GAP.
  - Sequence registers: sampled durations, target mode, and a command index 0..3.
- IDLE:
  - mode_ready_o=1.
  - On accept at edge N, classify the request:
    - Illegal request (mode 11, or NORMAL with any duration == 0): err_o=1 during cycle N+1; no commands; cur_mode unchanged; stay IDLE.
    - Same mode as cur_mode_o for OFF or BLINK: accepted, no commands, no error.
    - NORMAL while cur_mode=NORMAL: sequence is SET_RED, SET_YELLOW, SET_GREEN (no ON).
    - NORMAL from OFF or BLINK: SET_RED(red), SET_YELLOW(yellow), SET_GREEN(green), then ON.
    - OFF: single OFF. BLINK: single BLINK.
- ISSUE:
  - cmd_valid_o=1 for exactly one cycle, with cmd_type_o/cmd_data_o valid in that cycle.
  - First command appears in cycle N+1 after the accepting edge N.
  - Next state is GAP if CMD_GAP>0, else ISSUE for the next command.
  - After the last command, next state is IDLE.
- GAP:
  - Counts CMD_GAP cycles with cmd_valid_o=0, then returns to ISSUE.
  - No GAP after the last command of a sequence.
- cmd_type_o/cmd_data_o hold their last values while cmd_valid_o=0.
- cur_mode_o updates on the edge ending the last command's valid cycle.
  - A NORMAL sequence of 4 commands with CMD_GAP=2 completes in 4 + 3×2 = 10 cycles.
  - mode_ready_o returns high in the cycle after the last valid.
- busy_o=1 in ISSUE/GAP. mode_ready_o=0 there; requests stall (no queueing, no preemption).
- Gap counter width: $clog2(CMD_GAP+1), minimum 1 bit.
- Durations are passed through unmodified; no clamping.
- Reset mid-sequence: outputs return to reset values immediately and the sequence is abandoned.
  - The downstream block may hold partial configuration; the host re-issues the request.

Optional Feature:
- Macro TLS_AUTO_START_EN.
  - Defined: on the first cycle after reset release, the FSM enters a NORMAL sequence using DEF_RED_MS/DEF_YELLOW_MS/DEF_GREEN_MS, as if a NORMAL request had been accepted from OFF.
    - mode_ready_o stays 0 until that sequence completes; cur_mode_o becomes 01.
  - Undefined: after reset the block idles in OFF with mode_ready_o=1 and issues nothing until a request.

Test Plan:
- NORMAL from OFF, red=10, yellow=3, green=8, CMD_GAP=2 -> valid strobes at cycles N+1, N+4, N+7, N+10 with (4,10), (5,3), (3,8), (0,0); cur_mode_o=01 after N+10; mode_ready_o=1 at N+11.
- BLINK then OFF, CMD_GAP=0 -> one (2,0) strobe at N+1; then one (1,0) strobe one cycle after second accept; cur_mode_o 10 then 00.
- NORMAL while NORMAL, red=5, yellow=2, green=6 -> exactly three strobes (4,5), (5,2), (3,6); no ON; cur_mode_o stays 01.
- Illegal requests: mode=11, and NORMAL with green=0 -> each accepted, err_o pulses one cycle, zero strobes, cur_mode_o unchanged.
- mode_valid_i held high during a busy sequence with a different mode -> mode_ready_o=0 until completion; request then accepted; no strobes lost or merged.
- arst_ni pulsed low between 2nd and 3rd strobe -> cmd_valid_o=0 and cur_mode_o=00 immediately; no further strobes; with TLS_AUTO_START_EN, the default 4-command sequence (4,10), (5,3), (3,8), (0,0) follows release.
